// File: rtl/rff_reset_sequencer.sv
// Staged reset release for N_DOM negedge/async-reset register banks.
// Domains leave reset one at a time in index order, each gated by its ready ack.
module rff_reset_sequencer #(
   parameter int N_DOM       = 4,
   parameter int HOLD_CYC    = 8,
   parameter int GAP_CYC     = 4,
   parameter int ACK_TIMEOUT = 16,
   parameter int CW          = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req,
   input  logic [N_DOM-1:0]          dom_ack,
   output logic [N_DOM-1:0]          dom_rst,
   output logic [$clog2(N_DOM)-1:0]  cur_dom,
   output logic                      busy,
   output logic                      done,
   output logic [N_DOM-1:0]          timeout_err
);

   localparam int DW = $clog2(N_DOM);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
   // GAP runs one count past GAP_CYC-1; the cur_dom increment takes its own edge.
   localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYC);
   localparam logic [DW-1:0] DOM_LAST  = DW'(N_DOM - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_RELEASE,
      S_WAIT_ACK,
      S_GAP,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [N_DOM-1:0]  r_dom_rst;
   logic [DW-1:0]     r_cur_dom;
   logic              r_busy;
   logic              r_done;
   logic [N_DOM-1:0]  r_timeout_err;

   logic [N_DOM-1:0]  w_cur_onehot;
   logic              w_ack_cur;
   logic              w_last_dom;

   genvar gi;
   generate
      for (gi = 0; gi < N_DOM; gi++) begin : g_sel
         assign w_cur_onehot[gi] = (r_cur_dom == DW'(gi));
      end
   endgenerate

   // Only the domain currently being released may advance the sequence.
   assign w_ack_cur  = |(dom_ack & w_cur_onehot);
   assign w_last_dom = (r_cur_dom == DOM_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_HOLD;
         r_cnt         <= '0;
         r_dom_rst     <= '1;
         r_cur_dom     <= '0;
         r_busy        <= 1'b1;
         r_done        <= 1'b0;
         r_timeout_err <= '0;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_state <= S_RELEASE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end

            S_RELEASE: begin
               r_dom_rst <= r_dom_rst & ~w_cur_onehot;
               r_state   <= S_WAIT_ACK;
               r_cnt     <= '0;
            end

            S_WAIT_ACK: begin
               if (w_ack_cur || (r_cnt == ACK_LAST)) begin
                  // A timed-out domain stays released; it is only flagged.
                  if (!w_ack_cur) begin
                     r_timeout_err <= r_timeout_err | w_cur_onehot;
                  end
                  if (w_last_dom) begin
                     r_state   <= S_DONE;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_dom_rst <= '0;
                  end else begin
                     r_state <= S_GAP;
                  end
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end

            S_GAP: begin
               if (r_cnt == GAP_END) begin
                  r_cur_dom <= r_cur_dom + DW'(1);
                  r_state   <= S_RELEASE;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end

            S_DONE: begin
               if (req) begin
                  r_state       <= S_HOLD;
                  r_cnt         <= '0;
                  r_dom_rst     <= '1;
                  r_cur_dom     <= '0;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
                  r_timeout_err <= '0;
               end
            end

            default: begin
               r_state <= S_HOLD;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign dom_rst     = r_dom_rst;
   assign cur_dom     = r_cur_dom;
   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rff_reset_sequencer.sv
// Bench for rff_reset_sequencer: scenario table with edge-timed expectations,
// checked every cycle through an expected-value queue.
module tb_rff_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic [3:0] dom_ack = 4'b0000;
   logic [3:0] dom_rst;
   logic [1:0] cur_dom;
   logic       busy;
   logic       done;
   logic [3:0] timeout_err;

   rff_reset_sequencer #(
      .N_DOM(4), .HOLD_CYC(8), .GAP_CYC(4), .ACK_TIMEOUT(16), .CW(8)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .dom_ack(dom_ack),
      .dom_rst(dom_rst), .cur_dom(cur_dom), .busy(busy), .done(done),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Packed arrays are indexed [3]..[0]; edge numbers are counted from the
   // last reset/restart edge (edge 0). 255 means "never".
   typedef struct {
      int               cycles;
      int               mode;      // 0: ack[i] = e>=ack_on[i]; 1: 1 at e==ack_on[i], random otherwise
      logic [3:0][7:0]  ack_on;
      logic [3:0][7:0]  rel;       // edge at which dom_rst[i] drops
      int               done_e;
      logic [3:0]       terr;
      int               terr_e;
      logic [3:0][7:0]  req_ign;   // absolute edges with a req that must be ignored
      int               restart;   // absolute edge of req while DONE (0 = none)
      int               rst_at;    // absolute edge with reset asserted (0 = none)
   } scen_t;

   localparam logic [11:0] RST_EXP = {4'hF, 2'd0, 1'b1, 1'b0, 4'h0};

   scen_t       sc[7];
   logic [11:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [11:0] exp_at(input int e, input scen_t s);
      logic [3:0] r;
      int         c;
      logic       dn;
      logic [3:0] te;
      for (int i = 0; i < 4; i++) r[i] = (e < int'(s.rel[i]));
      c = 0;
      for (int i = 1; i < 4; i++) if (e >= int'(s.rel[i]) - 1) c++;
      dn = (e >= s.done_e);
      te = (e >= s.terr_e) ? s.terr : 4'h0;
      return {r, 2'(c), ~dn, dn, te};
   endfunction

   function automatic logic [3:0] ack_at(input int e, input scen_t s);
      logic [3:0] a;
      for (int i = 0; i < 4; i++) begin
         if (s.mode == 0) a[i] = (e >= int'(s.ack_on[i]));
         else             a[i] = (e == int'(s.ack_on[i])) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      return a;
   endfunction

   task automatic step(input logic rst_i, input logic req_i, input logic [3:0] ack_i,
                       input logic [11:0] exp_v, input string tag, input int k);
      logic [11:0] got;
      logic [11:0] want;
      @(negedge clk);
      reset   = rst_i;
      req     = req_i;
      dom_ack = ack_i;
      exp_q.push_back(exp_v);
      @(posedge clk);
      #1;
      got = {dom_rst, cur_dom, busy, done, timeout_err};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s k=%0d scoreboard empty got=%h", tag, k, got);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got rst=%b cur=%0d busy=%b done=%b terr=%b required=%h actual=%h",
                     tag, k, got[11:8], got[7:6], got[5], got[4], got[3:0], want, got);
         end else begin
            $display("ok   %s k=%0d rst=%b cur=%0d busy=%b done=%b terr=%b",
                     tag, k, got[11:8], got[7:6], got[5], got[4], got[3:0]);
         end
      end
   endtask

   initial begin
      // basic: acks tied high
      sc[0] = '{40, 0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd30, 8'd23, 8'd16, 8'd9}, 31,
                4'b0000, 255, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 0};
      // dom_ack[2] never arrives: 16 WAIT_ACK cycles then flag and continue
      sc[1] = '{55, 0, {8'd0, 8'd255, 8'd0, 8'd0}, {8'd45, 8'd23, 8'd16, 8'd9}, 46,
                4'b0100, 39, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 0};
      // same, then req in DONE restarts and clears the flag
      sc[2] = '{100, 0, {8'd0, 8'd255, 8'd0, 8'd0}, {8'd45, 8'd23, 8'd16, 8'd9}, 46,
                4'b0100, 39, {8'd0, 8'd0, 8'd0, 8'd0}, 50, 0};
      // req in HOLD, WAIT_ACK, GAP and on the edge entering DONE: ignored
      sc[3] = '{40, 0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd30, 8'd23, 8'd16, 8'd9}, 31,
                4'b0000, 255, {8'd31, 8'd12, 8'd10, 8'd4}, 0, 0};
      // reset in GAP with cur_dom=2, then full restart
      sc[4] = '{62, 0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd30, 8'd23, 8'd16, 8'd9}, 31,
                4'b0000, 255, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 27};
      // non-current acks toggle randomly; current ack only on first WAIT_ACK cycle
      sc[5] = '{40, 1, {8'd31, 8'd24, 8'd17, 8'd10}, {8'd30, 8'd23, 8'd16, 8'd9}, 31,
                4'b0000, 255, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 0};
      // dom_ack[1] arrives 3 cycles late: later domains shift by 3
      sc[6] = '{40, 0, {8'd0, 8'd0, 8'd20, 8'd0}, {8'd33, 8'd26, 8'd16, 8'd9}, 34,
                4'b0000, 255, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 0};

      for (int s = 0; s < 7; s++) begin
         string tag;
         int    base;
         int    e;
         logic  rq;
         tag = $sformatf("s%0d", s);
         step(1'b1, 1'b0, 4'h0, RST_EXP, {tag, "_rst"}, 0);
         step(1'b1, 1'b0, 4'h0, RST_EXP, {tag, "_rst"}, 0);
         base = 0;
         for (int k = 1; k <= sc[s].cycles; k++) begin
            if (k == sc[s].rst_at || k == sc[s].restart) base = k;
            e  = k - base;
            rq = (k == sc[s].restart);
            for (int j = 0; j < 4; j++) if (k == int'(sc[s].req_ign[j])) rq = 1'b1;
            step(k == sc[s].rst_at, rq, ack_at(e, sc[s]), exp_at(e, sc[s]), tag, k);
         end
      end

      // DONE is sticky under ack noise, then req restarts into HOLD and a
      // second req during HOLD changes nothing.
      for (int k = 1; k <= 4; k++)
         step(1'b0, 1'b0, 4'($urandom_range(0, 15)), {4'h0, 2'd3, 1'b0, 1'b1, 4'h0}, "done_hold", k);
      step(1'b0, 1'b1, 4'hF, RST_EXP, "req_restart", 5);
      step(1'b0, 1'b0, 4'hF, RST_EXP, "hold_after", 6);
      step(1'b0, 1'b1, 4'hF, RST_EXP, "req_in_hold", 7);
      for (int k = 8; k <= 13; k++)
         step(1'b0, 1'b0, 4'hF, RST_EXP, "hold_run", k);
      // edge 14 is 9 edges after the restart edge: dom_rst[0] drops
      step(1'b0, 1'b0, 4'hF, {4'hE, 2'd0, 1'b1, 1'b0, 4'h0}, "first_release", 14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
